// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the E stage of a 3-stage RV32I+Zicsr pipeline.
// Reads are combinational (pre-write value); CSR writes, trap entry/exit and counters commit on the clock edge.
module csr_trap_unit #(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_valid,
  input  logic [31:0] e_inst,
  input  logic [31:0] e_pc,
  input  logic [31:0] e_rs1_data,
  input  logic        e_zicsr,
  input  logic        e_ecall,
  input  logic        e_mret,
  input  logic        e_illegal_inst,
  output logic [31:0] csr_r_data,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        trap_pending
);
  logic [11:0] addr;
  logic [2:0]  funct3;
  logic [4:0]  uimm;
  assign addr   = e_inst[31:20];
  assign funct3 = e_inst[14:12];
  assign uimm   = e_inst[19:15];

  logic        mie, mpie;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] mcycle, minstret;

  logic mret_take, csr_we, inst_inc;
  logic [31:0] src, wdata;

  // Priority: illegal > ecall > mret > zicsr
  assign trap_pending = e_valid & (e_illegal_inst | e_ecall);
  assign mret_take    = e_valid & e_mret & ~e_illegal_inst & ~e_ecall;
  assign redirect     = trap_pending | mret_take;
  assign redirect_pc  = mret_take ? mepc : mtvec;
  assign inst_inc     = e_valid & ~trap_pending;

  // RS/RC with a zero source field are pure reads
  assign csr_we = e_valid & e_zicsr & ~trap_pending & ~mret_take &
                  ((funct3[1:0] == 2'b01) || ((funct3[1:0] != 2'b00) && (uimm != 5'd0)));
  assign src    = funct3[2] ? {27'd0, uimm} : e_rs1_data;

  always_comb begin
    csr_r_data = 32'd0;
    case (addr)
      12'h300: csr_r_data = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
      12'h301: csr_r_data = MISA_VAL;
      12'h305: csr_r_data = mtvec;
      12'h340: csr_r_data = mscratch;
      12'h341: csr_r_data = mepc;
      12'h342: csr_r_data = mcause;
      12'h343: csr_r_data = mtval;
      12'hB00, 12'hC00: csr_r_data = mcycle[31:0];
      12'hB80, 12'hC80: csr_r_data = mcycle[63:32];
      12'hB02, 12'hC02: csr_r_data = minstret[31:0];
      12'hB82, 12'hC82: csr_r_data = minstret[63:32];
      12'hF14: csr_r_data = HART_ID;
      default: csr_r_data = 32'd0;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b01:   wdata = src;
      2'b10:   wdata = csr_r_data | src;
      2'b11:   wdata = csr_r_data & ~src;
      default: wdata = csr_r_data;
    endcase
  end

  logic we_cyc_lo, we_cyc_hi, we_ret_lo, we_ret_hi;
  assign we_cyc_lo = csr_we && addr == 12'hB00;
  assign we_cyc_hi = csr_we && addr == 12'hB80;
  assign we_ret_lo = csr_we && addr == 12'hB02;
  assign we_ret_hi = csr_we && addr == 12'hB82;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= 32'd0;
      mscratch <= 32'd0;
      mepc     <= 32'd0;
      mcause   <= 32'd0;
      mtval    <= 32'd0;
    end else if (trap_pending) begin
      mpie   <= mie;
      mie    <= 1'b0;
      mepc   <= e_pc & ~32'd3;
      mcause <= e_illegal_inst ? 32'd2 : 32'd11;
      mtval  <= e_illegal_inst ? e_inst : 32'd0;
    end else if (mret_take) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (csr_we) begin
      case (addr)
        12'h300: begin mie <= wdata[3]; mpie <= wdata[7]; end
        12'h305: mtvec    <= wdata & ~32'd3;
        12'h340: mscratch <= wdata;
        12'h341: mepc     <= wdata & ~32'd3;
        12'h342: mcause   <= wdata;
        12'h343: mtval    <= wdata;
        default: ;
      endcase
    end
  end

  // A written half takes the write; the carry only follows a real low-half increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= 64'd0;
      minstret <= 64'd0;
    end else begin
      mcycle[31:0]    <= we_cyc_lo ? wdata : mcycle[31:0] + 32'd1;
      mcycle[63:32]   <= we_cyc_hi ? wdata :
                         mcycle[63:32] + 32'(!we_cyc_lo && (&mcycle[31:0]));
      minstret[31:0]  <= we_ret_lo ? wdata : minstret[31:0] + 32'(inst_inc);
      minstret[63:32] <= we_ret_hi ? wdata :
                         minstret[63:32] + 32'(inst_inc && !we_ret_lo && (&minstret[31:0]));
    end
  end
endmodule
